// File: rtl/uart_block_assembler_if.sv
// Byte-stream and block handshake bundle for uart_block_assembler.
// master: the assembler (consumes bytes, produces blocks).
// slave:  the environment (UART receiver plus crypto-core consumer).
interface uart_block_assembler_if #(
    parameter int BLOCK_BYTES = 16
);
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     rx_eop;
    logic [8*BLOCK_BYTES-1:0] blk_data;
    logic                     blk_valid;
    logic                     blk_ready;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  rx_eop,
        input  blk_ready,
        output blk_data,
        output blk_valid
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output rx_eop,
        output blk_ready,
        input  blk_data,
        input  blk_valid
    );
endinterface

// File: rtl/uart_block_assembler.sv
// uart_block_assembler: packs UART bytes into BLOCK_BYTES-wide blocks.
// One block can wait in the output register while the next one fills the
// assembly register, so the receiver never needs to be stalled until both
// are full. Short packets are discarded on end-of-packet; bytes with no
// room left are dropped and counted.
module uart_block_assembler #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    uart_block_assembler_if.master             bus,
    output logic [$clog2(BLOCK_BYTES+1)-1:0]   fill_cnt,
    output logic                               err_short,
    output logic                               err_drop,
    output logic [7:0]                         drop_cnt
);
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam int DW = 8 * BLOCK_BYTES;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_BYTES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_BYTES);
    localparam logic [7:0]    DROP_MAX = 8'hFF;

    generate
        if (BLOCK_BYTES < 2 || BLOCK_BYTES > 64) begin : g_bad_param
            $error("uart_block_assembler: BLOCK_BYTES must be in 2..64");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   asm_r;
    logic [DW-1:0]   blk_data_r;
    logic            blk_valid_r;
    logic [CW-1:0]   cnt_r;
    logic            err_short_r;
    logic            err_drop_r;
    logic [7:0]      drop_cnt_r;

    logic            slot_free_s;
    logic            handshake_s;
    logic [DW-1:0]   shifted_s;

    // Output-slot availability and the assembly register with the new byte shifted in.
    always_comb begin
        slot_free_s = !blk_valid_r || bus.blk_ready;
        handshake_s = blk_valid_r && bus.blk_ready;
        shifted_s   = {asm_r[DW-9:0], bus.rx_data};
    end

    // Assembler FSM with all state, data and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_COLLECT;
            asm_r       <= {DW{1'b0}};
            blk_data_r  <= {DW{1'b0}};
            blk_valid_r <= 1'b0;
            cnt_r       <= CNT_ZERO;
            err_short_r <= 1'b0;
            err_drop_r  <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            // Error flags are single-cycle pulses.
            err_short_r <= 1'b0;
            err_drop_r  <= 1'b0;

            // A completed handshake empties the slot unless a reload below refills it.
            if (handshake_s) begin
                blk_valid_r <= 1'b0;
            end

            case (state_r)
                ST_COLLECT: begin
                    if (bus.rx_valid) begin
                        if (cnt_r < CNT_LAST) begin
                            // Ordinary byte; rx_eop then always leaves a partial block.
                            asm_r <= shifted_s;
                            if (bus.rx_eop) begin
                                cnt_r       <= CNT_ZERO;
                                err_short_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end else if (slot_free_s) begin
                            // Final byte goes straight to the output, bypassing asm_r.
                            blk_data_r  <= shifted_s;
                            blk_valid_r <= 1'b1;
                            cnt_r       <= CNT_ZERO;
                        end else begin
                            // Final byte with the slot busy: hold the full block.
                            asm_r   <= shifted_s;
                            cnt_r   <= CNT_FULL;
                            state_r <= ST_FULL;
                        end
                    end else if (bus.rx_eop && (cnt_r != CNT_ZERO)) begin
                        cnt_r       <= CNT_ZERO;
                        err_short_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end

                ST_FULL: begin
                    if (slot_free_s) begin
                        blk_data_r  <= asm_r;
                        blk_valid_r <= 1'b1;
                        state_r     <= ST_COLLECT;
                        if (bus.rx_valid && !bus.rx_eop) begin
                            // Only the low byte matters once the count restarts at one.
                            asm_r <= shifted_s;
                            cnt_r <= CNT_ONE;
                        end else if (bus.rx_valid) begin
                            // The new one-byte partial is ended immediately.
                            cnt_r       <= CNT_ZERO;
                            err_short_r <= 1'b1;
                        end else begin
                            cnt_r <= CNT_ZERO;
                        end
                    end else if (bus.rx_valid) begin
                        // No room anywhere: drop and count; a full block ignores rx_eop.
                        err_drop_r <= 1'b1;
                        if (drop_cnt_r != DROP_MAX) begin
                            drop_cnt_r <= drop_cnt_r + 8'd1;
                        end else begin
                            drop_cnt_r <= drop_cnt_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end

                default: begin
                    state_r <= ST_COLLECT;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.blk_data  = blk_data_r;
    assign bus.blk_valid = blk_valid_r;
    assign fill_cnt      = cnt_r;
    assign err_short     = err_short_r;
    assign err_drop      = err_drop_r;
    assign drop_cnt      = drop_cnt_r;

    uart_block_assembler_chk #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_data  (blk_data_r),
        .blk_valid (blk_valid_r),
        .blk_ready (bus.blk_ready),
        .fill_cnt  (cnt_r),
        .err_short (err_short_r),
        .err_drop  (err_drop_r),
        .drop_cnt  (drop_cnt_r)
    );
endmodule

// Protocol checker for uart_block_assembler outputs.
module uart_block_assembler_chk #(
    parameter int BLOCK_BYTES = 16
) (
    input logic                               clk,
    input logic                               rst_n,
    input logic [8*BLOCK_BYTES-1:0]           blk_data,
    input logic                               blk_valid,
    input logic                               blk_ready,
    input logic [$clog2(BLOCK_BYTES+1)-1:0]   fill_cnt,
    input logic                               err_short,
    input logic                               err_drop,
    input logic [7:0]                         drop_cnt
);
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_BYTES);

    a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (blk_valid && !blk_ready) |=> $stable(blk_data));

    a_fill_range: assert property (@(posedge clk) disable iff (!rst_n)
        fill_cnt <= CNT_FULL);

    a_err_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(err_short && err_drop));

    a_drop_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> (drop_cnt >= $past(drop_cnt)));
endmodule

// File: tb/tb_uart_block_assembler.sv
// Self-checking bench for uart_block_assembler (BLOCK_BYTES=16 and 2).
module tb_uart_block_assembler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_block_assembler_if #(.BLOCK_BYTES(16)) bus ();
    uart_block_assembler_if #(.BLOCK_BYTES(2))  bus2 ();

    logic [4:0] fill_cnt;
    logic       err_short;
    logic       err_drop;
    logic [7:0] drop_cnt;
    logic [1:0] fill_cnt2;
    logic       err_short2;
    logic       err_drop2;
    logic [7:0] drop_cnt2;

    uart_block_assembler #(.BLOCK_BYTES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fill_cnt(fill_cnt),
        .err_short(err_short), .err_drop(err_drop), .drop_cnt(drop_cnt)
    );

    uart_block_assembler #(.BLOCK_BYTES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .fill_cnt(fill_cnt2),
        .err_short(err_short2), .err_drop(err_drop2), .drop_cnt(drop_cnt2)
    );

    int pass_cnt = 0;
    int chk_cnt = 0;
    int short_seen = 0;
    int drop_seen = 0;
    logic [127:0] exp_q[$];
    logic [127:0] exp_blk;
    logic [127:0] sb_blk;

    // Scoreboard: every handshake must deliver the oldest expected block.
    always @(negedge clk) begin
        if (err_short) short_seen = short_seen + 1;
        if (err_drop) drop_seen = drop_seen + 1;
        if (rst_n && bus.blk_valid && bus.blk_ready) begin
            chk_cnt = chk_cnt + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got block %h, expected none", bus.blk_data);
            end else begin
                sb_blk = exp_q.pop_front();
                if (bus.blk_data !== sb_blk)
                    $display("FAIL sb_block: got %h, expected %h", bus.blk_data, sb_blk);
                else
                    pass_cnt = pass_cnt + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic eop);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        bus.rx_eop   = eop;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_eop   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        chk_cnt++; if (bus.blk_valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", bus.blk_valid); else pass_cnt++;
        chk_cnt++; if (bus.blk_data !== 128'd0) $display("FAIL rst_data: got %h, expected 0", bus.blk_data); else pass_cnt++;
        chk_cnt++; if (fill_cnt !== 5'd0 || drop_cnt !== 8'd0) $display("FAIL rst_cnts: got fill %0d drop %0d, expected 0 0", fill_cnt, drop_cnt); else pass_cnt++;
        chk_cnt++; if (err_short !== 1'b0 || err_drop !== 1'b0) $display("FAIL rst_errs: got %b%b, expected 00", err_short, err_drop); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int s0, d0;
        s0 = short_seen; d0 = drop_seen;
        bus.blk_ready = 1'b1;
        exp_blk = 128'd0;
        for (int i = 0; i < 16; i++) begin
            exp_blk = {exp_blk[119:0], 8'(i)};
            if (i == 15) exp_q.push_back(exp_blk);
            send(8'(i), 1'b0);
        end
        chk_cnt++; if (bus.blk_valid !== 1'b1) $display("FAIL basic_valid: got %b, expected 1", bus.blk_valid); else pass_cnt++;
        chk_cnt++; if (bus.blk_data !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL basic_data: got %h, expected 000102..0F", bus.blk_data); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.blk_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b, expected 0", bus.blk_valid); else pass_cnt++;
        chk_cnt++; if (short_seen != s0 || drop_seen != d0) $display("FAIL basic_errs: got short %0d drop %0d, expected none", short_seen - s0, drop_seen - d0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_blk = {exp_blk[119:0], 8'(i)};
            if (i == 15 || i == 31) exp_q.push_back(exp_blk);
            send(8'(i), 1'b0);
        end
        chk_cnt++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL bp_held: got v=%b %h, expected v=1 000102..0F", bus.blk_valid, bus.blk_data); else pass_cnt++;
        chk_cnt++; if (fill_cnt !== 5'd16) $display("FAIL bp_fill_full: got %0d, expected 16", fill_cnt); else pass_cnt++;
        send(8'hAA, 1'b0);
        chk_cnt++; if (err_drop !== 1'b1) $display("FAIL bp_err_drop: got %b, expected 1", err_drop); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 8'd1) $display("FAIL bp_drop_cnt: got %0d, expected 1", drop_cnt); else pass_cnt++;
        tick();
        chk_cnt++; if (err_drop !== 1'b0) $display("FAIL bp_drop_pulse: got %b, expected 0", err_drop); else pass_cnt++;
        bus.blk_ready = 1'b1;
        tick();
        bus.blk_ready = 1'b0;
        chk_cnt++; if (bus.blk_valid !== 1'b1) $display("FAIL bp_reload_valid: got %b, expected 1", bus.blk_valid); else pass_cnt++;
        chk_cnt++; if (bus.blk_data !== 128'h101112131415161718191A1B1C1D1E1F) $display("FAIL bp_reload_data: got %h, expected 101112..1F", bus.blk_data); else pass_cnt++;
        chk_cnt++; if (fill_cnt !== 5'd0) $display("FAIL bp_fill_empty: got %0d, expected 0", fill_cnt); else pass_cnt++;
        bus.blk_ready = 1'b1;
        tick();
        bus.blk_ready = 1'b0;
        tick();
        chk_cnt++; if (bus.blk_valid !== 1'b0) $display("FAIL bp_drained: got %b, expected 0", bus.blk_valid); else pass_cnt++;
    endtask

    task automatic test_short();
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b0);
        chk_cnt++; if (fill_cnt !== 5'd5) $display("FAIL short_fill5: got %0d, expected 5", fill_cnt); else pass_cnt++;
        bus.rx_eop = 1'b1;
        tick();
        bus.rx_eop = 1'b0;
        chk_cnt++; if (err_short !== 1'b1 || fill_cnt !== 5'd0) $display("FAIL short_discard: got err %b fill %0d, expected 1 0", err_short, fill_cnt); else pass_cnt++;
        tick();
        chk_cnt++; if (err_short !== 1'b0) $display("FAIL short_pulse: got %b, expected 0", err_short); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            exp_blk = {exp_blk[119:0], 8'h80 + 8'(i)};
            if (i == 15) exp_q.push_back(exp_blk);
            send(8'h80 + 8'(i), 1'b0);
        end
        chk_cnt++; if (bus.blk_data !== 128'h808182838485868788898A8B8C8D8E8F) $display("FAIL short_clean: got %h, expected 808182..8F", bus.blk_data); else pass_cnt++;
        tick();
    endtask

    task automatic test_simultaneous();
        int s0;
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_blk = {exp_blk[119:0], 8'h20 + 8'(i)};
            if (i == 15 || i == 31) exp_q.push_back(exp_blk);
            send(8'h20 + 8'(i), 1'b0);
        end
        chk_cnt++; if (fill_cnt !== 5'd16) $display("FAIL sim_full: got %0d, expected 16", fill_cnt); else pass_cnt++;
        bus.blk_ready = 1'b1;
        send(8'h77, 1'b0);
        chk_cnt++; if (fill_cnt !== 5'd1) $display("FAIL sim_landed: got fill %0d, expected 1", fill_cnt); else pass_cnt++;
        chk_cnt++; if (err_drop !== 1'b0 || drop_cnt !== 8'd1) $display("FAIL sim_nodrop: got err %b cnt %0d, expected 0 1", err_drop, drop_cnt); else pass_cnt++;
        chk_cnt++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== 128'h303132333435363738393A3B3C3D3E3F) $display("FAIL sim_reload: got v=%b %h, expected v=1 303132..3F", bus.blk_valid, bus.blk_data); else pass_cnt++;
        tick();
        bus.rx_eop = 1'b1;
        tick();
        bus.rx_eop = 1'b0;
        chk_cnt++; if (err_short !== 1'b1 || fill_cnt !== 5'd0) $display("FAIL sim_flush: got err %b fill %0d, expected 1 0", err_short, fill_cnt); else pass_cnt++;
        tick();
        s0 = short_seen;
        for (int i = 0; i < 16; i++) begin
            exp_blk = {exp_blk[119:0], 8'h90 + 8'(i)};
            if (i == 15) exp_q.push_back(exp_blk);
            send(8'h90 + 8'(i), (i == 15) ? 1'b1 : 1'b0);
        end
        chk_cnt++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== 128'h909192939495969798999A9B9C9D9E9F) $display("FAIL eop_last_block: got v=%b %h, expected v=1 909192..9F", bus.blk_valid, bus.blk_data); else pass_cnt++;
        tick();
        chk_cnt++; if (short_seen != s0 || fill_cnt !== 5'd0) $display("FAIL eop_last_noshort: got shorts %0d fill %0d, expected 0 0", short_seen - s0, fill_cnt); else pass_cnt++;
    endtask

    task automatic test_saturation();
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_blk = {exp_blk[119:0], 8'hC0 + 8'(i)};
            if (i == 15 || i == 31) exp_q.push_back(exp_blk);
            send(8'hC0 + 8'(i), 1'b0);
        end
        for (int k = 0; k < 300; k++) send(8'hEE, 1'b0);
        chk_cnt++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop_cnt: got %0d, expected 255", drop_cnt); else pass_cnt++;
        chk_cnt++; if (fill_cnt !== 5'd16 || bus.blk_data !== 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF) $display("FAIL sat_held: got fill %0d %h, expected 16 C0..CF", fill_cnt, bus.blk_data); else pass_cnt++;
        bus.blk_ready = 1'b1;
        tick(); tick(); tick();
        bus.blk_ready = 1'b0;
        chk_cnt++; if (bus.blk_valid !== 1'b0) $display("FAIL sat_drained: got %b, expected 0", bus.blk_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.blk_ready = 1'b0;
        for (int i = 0; i < 23; i++) send(8'h01 + 8'(i), 1'b0);
        chk_cnt++; if (fill_cnt !== 5'd7 || bus.blk_valid !== 1'b1) $display("FAIL rm_setup: got fill %0d v=%b, expected 7 1", fill_cnt, bus.blk_valid); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (bus.blk_valid !== 1'b0 || bus.blk_data !== 128'd0) $display("FAIL rm_async_blk: got v=%b %h, expected 0 0", bus.blk_valid, bus.blk_data); else pass_cnt++;
        chk_cnt++; if (fill_cnt !== 5'd0 || drop_cnt !== 8'd0) $display("FAIL rm_async_cnts: got fill %0d drop %0d, expected 0 0", fill_cnt, drop_cnt); else pass_cnt++;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk_cnt++; if (err_short !== 1'b0 || err_drop !== 1'b0 || bus.blk_valid !== 1'b0) $display("FAIL rm_after: got %b%b v=%b, expected 00 v=0", err_short, err_drop, bus.blk_valid); else pass_cnt++;
    endtask

    task automatic test_bb2();
        bus2.blk_ready = 1'b1;
        bus2.rx_valid = 1'b1;
        bus2.rx_data = 8'hDE;
        tick();
        chk_cnt++; if (fill_cnt2 !== 2'd1) $display("FAIL bb2_fill: got %0d, expected 1", fill_cnt2); else pass_cnt++;
        bus2.rx_data = 8'hAD;
        tick();
        bus2.rx_valid = 1'b0;
        chk_cnt++; if (bus2.blk_valid !== 1'b1 || bus2.blk_data !== 16'hDEAD) $display("FAIL bb2_block: got v=%b %h, expected v=1 DEAD", bus2.blk_valid, bus2.blk_data); else pass_cnt++;
        chk_cnt++; if (fill_cnt2 !== 2'd0) $display("FAIL bb2_fill_empty: got %0d, expected 0", fill_cnt2); else pass_cnt++;
        tick();
    endtask

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_eop = 1'b0; bus.blk_ready = 1'b0;
        bus2.rx_valid = 1'b0; bus2.rx_data = 8'h00; bus2.rx_eop = 1'b0; bus2.blk_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_bb2();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d blocks pending, expected 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/uart_block_assembler.md
# uart_block_assembler

Collects the byte stream produced by the UART receiver (data-ready pulse, data byte, end-of-packet pulse) and assembles it into fixed-size blocks for the crypto core. Each block is presented on a valid/ready interface.

- Assembly is double-buffered, so bytes keep arriving while the core holds the previous block.
- A short packet, terminated by the receiver's end-of-packet pulse, is discarded and flagged.
- A byte that cannot be stored is dropped, flagged and counted.

## Interface
Parameters:
- BLOCK_BYTES, default 16: bytes per block; legal range 2..64.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse; rx_data holds a received byte.
- rx_data  in  8  received byte.
- rx_eop  in  1  one-cycle pulse; the receiver line has gone idle (packet end).
- blk_data  out  8*BLOCK_BYTES  assembled block; first received byte is in the top byte [8*BLOCK_BYTES-1 -: 8].
- blk_valid  out  1  blk_data holds a block.
- blk_ready  in  1  consumer accepts the block when blk_valid && blk_ready at a rising clk edge.
- fill_cnt  out  clog2(BLOCK_BYTES+1)  bytes currently held in the assembly register.
- err_short  out  1  one-cycle pulse; a partial block was discarded on rx_eop.
- err_drop  out  1  one-cycle pulse; an incoming byte was dropped.
- drop_cnt  out  8  saturating count of dropped bytes; saturates at 255.

## Operation
Storage:
- Assembly register asm (8*BLOCK_BYTES bits) plus fill counter cnt.
- Output register blk_data plus blk_valid.
- Byte accept: asm <= {asm[8*BLOCK_BYTES-9:0], rx_data}; cnt <= cnt+1.

Output slot:
- slot_free = !blk_valid || blk_ready, evaluated in the current cycle.
- Handshake on the same edge with no transfer pending clears blk_valid.

Assembler states:
- COLLECT (cnt < BLOCK_BYTES):
  - rx_valid with cnt < BLOCK_BYTES-1: accept the byte.
  - rx_valid with cnt == BLOCK_BYTES-1 and slot_free: blk_data <= {asm[8*BLOCK_BYTES-9:0], rx_data}; blk_valid <= 1; cnt <= 0. This direct load bypasses asm.
  - rx_valid with cnt == BLOCK_BYTES-1 and !slot_free: accept the byte into asm; cnt <= BLOCK_BYTES; go to FULL.
- FULL (cnt == BLOCK_BYTES):
  - When slot_free: blk_data <= asm; blk_valid <= 1; cnt <= 0; return to COLLECT.
  - rx_valid in FULL in the same cycle as the transfer: the byte is accepted into the emptied assembler, and cnt ends at 1.
  - rx_valid in FULL without a transfer: the byte is dropped; err_drop pulses; drop_cnt increments, saturating at 255.

rx_eop:
- Evaluated after any same-cycle byte.
- If the resulting cnt is between 1 and BLOCK_BYTES-1: cnt <= 0 and err_short pulses.
- If cnt is 0 or BLOCK_BYTES: no effect; a full block is never discarded.

blk_data stability:
- blk_data is stable while blk_valid && !blk_ready.

## Timing
Reset values:
- blk_valid=0, blk_data=0, cnt/fill_cnt=0, err_short=0, err_drop=0, drop_cnt=0, state COLLECT.
- Reset mid-block discards all partial and held data immediately; no pulses are generated.

Latency:
- Final byte's rx_valid sampled at edge t with the slot free: blk_valid is high after edge t.
- Held block: it moves to the output on the first edge where slot_free is true; blk_valid remains continuously high across a back-to-back handshake-and-reload.

Throughput:
- One byte per cycle is sustainable when blk_ready is held high.

Outputs:
- err_short and err_drop are registered, high for exactly one cycle, in the cycle after the causing edge.
- fill_cnt is registered and equals cnt.

Back-pressure:
- No back-pressure to the receiver exists.
- Capacity before the first drop is 2*BLOCK_BYTES bytes: one held output block plus one full assembler.

## Test plan
Default BLOCK_BYTES=16 unless noted.
- Basic block: 16 bytes 0x00..0x0F with blk_ready=1 -> blk_valid high for 1 cycle after the 16th byte; blk_data=0x000102…0F; err flags stay 0.
- Back-pressure: blk_ready=0, send 32 bytes 0x00..0x1F, then a 33rd byte 0xAA.
  - After 32 bytes: blk_data=0x00..0F held; fill_cnt=16.
  - Byte 0xAA: err_drop pulses; drop_cnt=1.
  - Raise blk_ready for 1 cycle: blk_data becomes 0x10..1F; blk_valid stays 1; fill_cnt=0.
- Short packet: 5 bytes, then rx_eop -> err_short pulses; fill_cnt=0. The next 16 bytes form a clean block with no leftover of the first 5.
- Simultaneous events:
  - FULL state, rx_valid in the same cycle as the handshake: the new byte lands; fill_cnt=1; no drop.
  - 16th byte and rx_eop in the same cycle: block delivered; no err_short.
- Saturation and reset:
  - Force 300 drops -> drop_cnt=255.
  - Assert rst_n low mid-block (fill_cnt=7, blk_valid=1) -> all outputs at reset values asynchronously.
- BLOCK_BYTES=2: bytes 0xDE, 0xAD -> blk_data=0xDEAD after the second byte.
